// File: rtl/apb4_sram_pkg.sv
// Shared types and constants for the APB4 SRAM slave: FSM state encoding,
// default parameter values and the wait-state ceiling.
package apb4_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACCESS = 2'd3
  } apb_state_e;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_DEPTH       = 64;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int WAIT_CYCLES_MAX = 15;
  localparam int CNT_W           = 4;

  // Wait-counter load value, saturated so an out-of-range parameter cannot wrap.
  function automatic logic [CNT_W-1:0] wait_load(input int cycles);
    if (cycles > WAIT_CYCLES_MAX) begin
      wait_load = CNT_W'(WAIT_CYCLES_MAX);
    end else if (cycles < 0) begin
      wait_load = {CNT_W{1'b0}};
    end else begin
      wait_load = CNT_W'(cycles);
    end
  endfunction

endpackage

// File: rtl/apb4_sram_mem.sv
// Word-organised storage with asynchronous read and byte-enabled synchronous
// write. Contents are deliberately not reset.
module apb4_sram_mem
  import apb4_sram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = 6
) (
  input  logic                clk,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [AW-1:0]       waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [AW-1:0]       raddr,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Byte-lane write of the selected word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (be[b]) begin
          mem_r[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/apb4_sram_slave.sv
// APB4 slave fronting a small SRAM with configurable wait states and error
// response. Optional byte strobes are enabled with APB4_SRAM_PSTRB_EN.
module apb4_sram_slave
  import apb4_sram_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
`ifdef APB4_SRAM_PSTRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr
);

  localparam int BYTES  = DATA_W / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_state_e        state_r;
  apb_state_e        cur_state_s;
  apb_state_e        next_state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_next_s;
  logic [MEM_AW-1:0] addr_r;
  logic              write_r;
  logic              err_r;
  logic              pready_r;
  logic              pslverr_r;
  logic [DATA_W-1:0] prdata_r;

  logic [ADDR_W-1:0] word_idx_s;
  logic              misalign_s;
  logic              range_err_s;
  logic              err_s;
  logic              err_cur_s;
  logic              pready_next_s;
  logic              pslverr_next_s;
  logic [DATA_W-1:0] prdata_next_s;
  logic              mem_we_s;
  logic [BYTES-1:0]  be_s;
  logic [DATA_W-1:0] mem_rdata_s;

  // Address decode: word index, alignment and range checks on the live bus address.
  always_comb begin
    word_idx_s  = paddr >> OFF_W;
    misalign_s  = (paddr & ADDR_W'(BYTES - 1)) != {ADDR_W{1'b0}};
    range_err_s = word_idx_s >= ADDR_W'(DEPTH);
    err_s       = misalign_s | range_err_s;
  end

  // Byte enables: strobes when present, otherwise full-word writes.
  always_comb begin
`ifdef APB4_SRAM_PSTRB_EN
    be_s = pstrb;
`else
    be_s = {BYTES{1'b1}};
`endif
  end

  // SETUP is the bus setup cycle itself, recognised from IDLE and the live bus,
  // so that zero wait states can finish in the very first access cycle.
  always_comb begin
    if (state_r == ST_IDLE && psel && !penable) begin
      cur_state_s = ST_SETUP;
    end else begin
      cur_state_s = state_r;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    next_state_s = ST_IDLE;
    cnt_next_s   = {CNT_W{1'b0}};
    case (cur_state_s)
      ST_IDLE: begin
        next_state_s = ST_IDLE;
        cnt_next_s   = {CNT_W{1'b0}};
      end
      ST_SETUP: begin
        next_state_s = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
        cnt_next_s   = wait_load(WAIT_CYCLES);
      end
      ST_WAIT: begin
        if (!psel) begin
          next_state_s = ST_IDLE;
          cnt_next_s   = {CNT_W{1'b0}};
        end else if (cnt_r <= 4'd1) begin
          next_state_s = ST_ACCESS;
          cnt_next_s   = {CNT_W{1'b0}};
        end else begin
          next_state_s = ST_WAIT;
          cnt_next_s   = cnt_r - 4'd1;
        end
      end
      ST_ACCESS: begin
        next_state_s = ST_IDLE;
        cnt_next_s   = {CNT_W{1'b0}};
      end
      default: begin
        next_state_s = ST_IDLE;
        cnt_next_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output decode: response flags, read capture and write enable.
  always_comb begin
    if (cur_state_s == ST_SETUP) begin
      err_cur_s = err_s;
    end else begin
      err_cur_s = err_r;
    end
    pready_next_s  = (next_state_s == ST_ACCESS);
    pslverr_next_s = (next_state_s == ST_ACCESS) && err_cur_s;
    if (cur_state_s == ST_SETUP && !pwrite) begin
      prdata_next_s = err_s ? {DATA_W{1'b0}} : mem_rdata_s;
    end else begin
      prdata_next_s = prdata_r;
    end
    mem_we_s = (cur_state_s == ST_ACCESS) && psel && penable && write_r && !err_r;
  end

  // State, counter and registered outputs.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
      prdata_r  <= {DATA_W{1'b0}};
    end else begin
      state_r   <= next_state_s;
      cnt_r     <= cnt_next_s;
      pready_r  <= pready_next_s;
      pslverr_r <= pslverr_next_s;
      prdata_r  <= prdata_next_s;
    end
  end

  // Transfer attributes captured in SETUP and used for the ACCESS write.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      addr_r  <= {MEM_AW{1'b0}};
      write_r <= 1'b0;
      err_r   <= 1'b0;
    end else if (cur_state_s == ST_SETUP) begin
      addr_r  <= word_idx_s[MEM_AW-1:0];
      write_r <= pwrite;
      err_r   <= err_s;
    end else begin
      addr_r  <= addr_r;
      write_r <= write_r;
      err_r   <= err_r;
    end
  end

  apb4_sram_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (MEM_AW)
  ) u_mem (
    .clk    (pclk),
    .we     (mem_we_s),
    .be     (be_s),
    .waddr  (addr_r),
    .wdata  (pwdata),
    .raddr  (word_idx_s[MEM_AW-1:0]),
    .rdata  (mem_rdata_s)
  );

  assign prdata  = prdata_r;
  assign pready  = pready_r;
  assign pslverr = pslverr_r;

endmodule

// File: tb/tb_apb4_sram_slave.sv
// Scoreboard bench for apb4_sram_slave: one instance with 2 wait states and
// one with none, checked against a word-array reference model.
module tb_apb4_sram_slave;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    bit          err;
    logic [31:0] hold;
  } exp_t;

  logic        clk;
  logic        presetn;
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1;
  logic        pslverr0, pslverr1;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] model   [2][64];
  logic [31:0] last_rd [2];
  int          acc     [2];
  int          total;
  int          bad;

  apb4_sram_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(64), .WAIT_CYCLES(2)) dut (
    .pclk(clk), .presetn(presetn), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
`ifdef APB4_SRAM_PSTRB_EN
    .pstrb(pstrb[0]),
`endif
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );

  apb4_sram_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(64), .WAIT_CYCLES(0)) dut_z (
    .pclk(clk), .presetn(presetn), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
`ifdef APB4_SRAM_PSTRB_EN
    .pstrb(pstrb[1]),
`endif
    .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int w);
    return (w == 0) ? pready0 : pready1;
  endfunction

  // Monitor: every pready pops one expected response; pslverr never appears alone.
  task automatic mon(input int w, input logic sel, input logic en, input logic r,
                     input logic err, input logic [31:0] rd);
    exp_t e;
    int   wexp;
    wexp = (w == 0) ? 2 : 0;
    chk($sformatf("pslverr_only_with_pready%0d", w), {31'd0, err & ~r}, 32'd0);
    if (r) begin
      if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
        chk($sformatf("spurious_pready%0d", w), 32'd1, 32'd0);
      end else begin
        e = (w == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("latency%0d", w), acc[w], wexp);
        chk($sformatf("pslverr%0d", w), {31'd0, err}, {31'd0, e.err});
        chk($sformatf("prdata%0d", w), rd, e.rd ? e.data : e.hold);
      end
      acc[w] = 0;
    end else if (sel && en) begin
      acc[w]++;
    end else begin
      acc[w] = 0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, psel[0], penable[0], pready0, pslverr0, prdata0);
    mon(1, psel[1], penable[1], pready1, pslverr1, prdata1);
  end

  // Full transfer starting just after a rising edge; returns just after the edge ending pready.
  task automatic xfer(input int w, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb);
    exp_t e;
    bit   err;
    bit   done;
    int   idx;
`ifndef APB4_SRAM_PSTRB_EN
    strb = 4'hF;
`endif
    err   = (addr % 4 != 0) || (addr / 4 >= 64);
    idx   = int'(addr / 4);
    e.rd  = !wr;
    e.err = err;
    e.data = 32'd0;
    if (!wr) begin
      e.data     = err ? 32'd0 : model[w][idx];
      last_rd[w] = e.data;
    end else if (!err) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model[w][idx][b*8 +: 8] = data[b*8 +: 8];
      end
    end
    e.hold = last_rd[w];
    if (w == 0) q0.push_back(e); else q1.push_back(e);
    psel[w] = 1'b1; penable[w] = 1'b0; pwrite[w] = wr;
    paddr[w] = addr; pwdata[w] = data; pstrb[w] = strb;
    @(posedge clk); #1;
    penable[w] = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (rdy(w)) done = 1'b1;
    end
    chk($sformatf("transfer_completes%0d", w), {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    psel[w] = 1'b0; penable[w] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 32'($urandom_range(0, 63)) * 32'd4;
    else if (r == 7) return 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(1, 3));
    else return 32'($urandom_range(64, 200)) * 32'd4;
  endfunction

  initial begin
    bit          seen;
    logic [31:0] a [30];
    total = 0; bad = 0;
    acc[0] = 0; acc[1] = 0;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    for (int w = 0; w < 2; w++) begin
      psel[w] = 1'b0; penable[w] = 1'b0; pwrite[w] = 1'b0;
      paddr[w] = 32'd0; pwdata[w] = 32'd0; pstrb[w] = 4'hF;
    end
    presetn = 1'b0;
    #3;
    chk("reset_pready0", {31'd0, pready0}, 32'd0);
    chk("reset_pslverr0", {31'd0, pslverr0}, 32'd0);
    chk("reset_prdata0", prdata0, 32'd0);
    chk("reset_pready1", {31'd0, pready1}, 32'd0);
    chk("reset_pslverr1", {31'd0, pslverr1}, 32'd0);
    chk("reset_prdata1", prdata1, 32'd0);
    #20;
    @(posedge clk); #1;
    presetn = 1'b1;
    idle(1);

    for (int i = 0; i < 64; i++) xfer(0, 1'b1, 32'(i) * 32'd4, $urandom, 4'hF);
    for (int i = 0; i < 64; i++) xfer(1, 1'b1, 32'(i) * 32'd4, $urandom, 4'hF);
    idle(2);

    // Basic write/read with default wait states.
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    idle(1);
    xfer(0, 1'b0, 32'h10, 32'd0, 4'hF);
    idle(1);

    // Zero wait states, back-to-back.
    for (int i = 0; i < 30; i++) begin
      a[i] = 32'($urandom_range(0, 63)) * 32'd4;
      xfer(1, 1'b1, a[i], $urandom, 4'hF);
    end
    for (int i = 0; i < 30; i++) xfer(1, 1'b0, a[i], 32'd0, 4'hF);
    idle(1);

    // Error responses and boundaries.
    xfer(0, 1'b0, 32'h100, 32'd0, 4'hF);
    xfer(0, 1'b1, 32'h12, 32'h12345678, 4'hF);
    xfer(0, 1'b0, 32'h10, 32'd0, 4'hF);
    xfer(0, 1'b0, 32'hFC, 32'd0, 4'hF);
    xfer(0, 1'b1, 32'h100, 32'hA5A5A5A5, 4'hF);
    xfer(0, 1'b0, 32'h0, 32'd0, 4'hF);
    idle(1);

    // penable without a setup phase must be ignored.
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 32'h10;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (pready0) seen = 1'b1;
    end
    chk("no_pready_on_bad_protocol", {31'd0, seen}, 32'd0);
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    idle(1);

    // psel dropped during WAIT aborts the write.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 32'h8; pwdata[0] = ~model[0][2];
    @(posedge clk); #1;
    penable[0] = 1'b1;
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (pready0) seen = 1'b1;
    end
    chk("no_pready_after_psel_drop", {31'd0, seen}, 32'd0);
    @(posedge clk); #1;
    xfer(0, 1'b0, 32'h8, 32'd0, 4'hF);
    idle(1);

    // Reset in the middle of a write.
    xfer(0, 1'b1, 32'h4, 32'h11, 4'hF);
    xfer(0, 1'b0, 32'h4, 32'd0, 4'hF);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 32'h4; pwdata[0] = 32'h55; pstrb[0] = 4'hF;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    #1;
    presetn = 1'b0;
    #1;
    chk("reset_mid_pready", {31'd0, pready0}, 32'd0);
    chk("reset_mid_pslverr", {31'd0, pslverr0}, 32'd0);
    chk("reset_mid_prdata", prdata0, 32'd0);
    psel[0] = 1'b0; penable[0] = 1'b0;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    @(posedge clk); #1;
    presetn = 1'b1;
    idle(1);
    xfer(0, 1'b0, 32'h4, 32'd0, 4'hF);
    idle(1);

`ifdef APB4_SRAM_PSTRB_EN
    xfer(0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'hF);
    xfer(0, 1'b1, 32'h8, 32'h00000000, 4'b0101);
    xfer(0, 1'b0, 32'h8, 32'd0, 4'hF);
    chk("strobe_model", model[0][2], 32'hFF00FF00);
    xfer(0, 1'b1, 32'h8, 32'h12345678, 4'b0000);
    xfer(0, 1'b0, 32'h8, 32'd0, 4'hF);
    idle(1);
`endif

    // Randomised mix across both instances.
    for (int i = 0; i < 160; i++) begin
      xfer($urandom_range(0, 1), 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
           4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(4);
    chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb4_sram_slave.md
APB4_SRAM_SLAVE -- requirements
Module: apb4_sram_slave

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32: paddr width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 32: data width; legal values are 8, 16, 32 and 64.
REQ-003 The block SHALL have parameter DEPTH, default 64: number of DATA_W words of storage.
REQ-004 The block SHALL have parameter WAIT_CYCLES, default 2: wait states per transfer, legal range 0..15.
REQ-005 pclk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 presetn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 psel, input, 1 bit: slave select.
REQ-008 penable, input, 1 bit: access phase.
REQ-009 pwrite, input, 1 bit: 1 = write, 0 = read.
REQ-010 paddr, input, ADDR_W bits: byte address.
REQ-011 pwdata, input, DATA_W bits: write data.
REQ-012 pstrb, input, DATA_W/8 bits: byte write strobes; present only under APB4_SRAM_PSTRB_EN.
REQ-013 prdata, output, DATA_W bits: read data.
REQ-014 pready, output, 1 bit: transfer complete.
REQ-015 pslverr, output, 1 bit: transfer error.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, WAIT and ACCESS.
REQ-017 IDLE SHALL move to SETUP when psel=1 and penable=0.
REQ-018 SETUP SHALL move to WAIT when WAIT_CYCLES>0, otherwise to ACCESS.
REQ-019 WAIT SHALL decrement the wait counter, which is loaded with WAIT_CYCLES in SETUP, and SHALL move to ACCESS when the counter reaches 1.
REQ-020 ACCESS SHALL return to SETUP if the next cycle is a new setup, otherwise to IDLE.
REQ-021 pready SHALL be 1 only in ACCESS, so the first access cycle is cycle N and pready=1 in cycle N+WAIT_CYCLES.
REQ-022 Word index SHALL be paddr >> log2(DATA_W/8).
REQ-023 A transfer SHALL be an error when the word index is >= DEPTH or the low address bits are non-zero (misaligned).
REQ-024 pslverr SHALL be 1 only in the pready cycle of an errored transfer and 0 at all other times.
REQ-025 A non-errored write SHALL update storage at the rising edge ending its pready cycle, and at no other edge.
REQ-026 An errored write SHALL leave storage unchanged.
REQ-027 Read data SHALL be registered into prdata at the edge ending SETUP.
REQ-028 An errored read SHALL load prdata with 0.
REQ-029 prdata SHALL hold its value until the next read SETUP.
REQ-030 If psel drops during WAIT or ACCESS before pready, the FSM SHALL go to IDLE, no write SHALL occur, and the counter SHALL clear.
REQ-031 If penable=1 while in IDLE (protocol violation), the FSM SHALL stay in IDLE and pready SHALL stay 0.
REQ-032 Back-to-back transfers (ACCESS directly to SETUP) SHALL have no idle cycle inserted.

Reset
REQ-033 presetn=0 SHALL immediately force the FSM to IDLE, the counter to 0, pready=0, pslverr=0 and prdata=0.
REQ-034 Storage contents SHALL NOT be reset and SHALL be X until first written.
REQ-035 A reset during a write SHALL abort the write, leaving the target word unchanged.

Configuration
REQ-036 With APB4_SRAM_PSTRB_EN defined, only bytes whose pstrb bit is 1 SHALL be written; pstrb=0 with a valid address SHALL complete without error and change nothing.
REQ-037 Without APB4_SRAM_PSTRB_EN, the pstrb port SHALL be absent and every write SHALL update all bytes.

Structure
REQ-038 Package apb4_sram_pkg SHALL hold the FSM state enum, the default parameter constants and the WAIT_CYCLES maximum.
REQ-039 Sub-module apb4_sram_mem SHALL hold the storage array, with combinational read and a byte-enabled synchronous write.
REQ-040 apb4_sram_slave SHALL hold the FSM, the wait counter, address decode and error logic.

Verification
REQ-041 Defaults: write 0xDEADBEEF to 0x10, then read 0x10 -> prdata=0xDEADBEEF, pready high 2 cycles after penable rises, pslverr=0 on both.
REQ-042 WAIT_CYCLES=0: 30 back-to-back random writes then reads -> pready=1 in the first access cycle and all data matches.
REQ-043 Read 0x100 (index 64 >= DEPTH) and write 0x12 (misaligned) -> pslverr=1 with pready, prdata=0, storage unchanged.
REQ-044 With APB4_SRAM_PSTRB_EN: write 0xFFFFFFFF to 0x8, then write 0x00000000 with pstrb=0b0101 -> read returns 0xFF00FF00.
REQ-045 Assert presetn=0 during the WAIT of a write of 0x55 to 0x4 holding 0x11 -> outputs 0 at once, later read returns 0x11.
REQ-046 Drop psel during WAIT -> FSM in IDLE next cycle, pready never asserts, no write occurs.
